gcd_dispatch: RTL and testbench

//  Upstream job front-end for the gcd core. Accepts operand pairs on a valid/ready stream.

---
 rtl/gcd_dispatch_if.sv | 29 ++
 rtl/gcd_dispatch.sv | 164 ++++++++++++++++
 tb/tb_gcd_dispatch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_dispatch_if.sv
// rtl/gcd_dispatch_if.sv - job, core and result handshakes of the gcd dispatcher
// slave is the dispatcher's view; master is the view of the surrounding system.
interface gcd_dispatch_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_return;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_err;

  modport slave (
    input  in_valid, in_a, in_b, core_done, core_return, out_ready,
    output in_ready, core_a, core_b, core_start, out_valid, out_result, out_err
  );

  modport master (
    output in_valid, in_a, in_b, core_done, core_return, out_ready,
    input  in_ready, core_a, core_b, core_start, out_valid, out_result, out_err
  );
endinterface

// File: rtl/gcd_dispatch.sv
// rtl/gcd_dispatch.sv - queues gcd jobs, runs the core one job at a time, returns results
// Zero operands bypass the core; a hung core is abandoned after TIMEOUT_CYC cycles.
module gcd_dispatch #(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  gcd_dispatch_if.slave bus,
  output logic        busy,
  output logic [15:0] job_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [2*DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   core_a_q, core_a_d;
  logic [DATA_W-1:0]   core_b_q, core_b_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;
  logic [15:0]         job_cnt_q, job_cnt_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              out_fire;
  logic              head_zero;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_CNT);
  assign push       = bus.in_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign out_fire   = out_valid_q && bus.out_ready;
  assign {head_a, head_b} = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign head_zero  = (head_a == '0) || (head_b == '0);

  always_ff @(posedge ap_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_a, bus.in_b};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      timer_q      <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      job_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      timer_q      <= timer_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      out_result_q <= out_result_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      job_cnt_q    <= job_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = head_zero ? S_RESP : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.core_done || (timer_q == TIMER_MAX)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // out_valid trails entry into RESP by one edge, so result and flag are settled first.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW + 1)'(pop);
    timer_d      = timer_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    out_valid_d  = 1'b0;
    job_cnt_d    = job_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          core_a_d = head_a;
          core_b_d = head_b;
          timer_d  = '0;
          if (head_zero) begin
            out_result_d = head_a | head_b;
            out_err_d    = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (bus.core_done) begin
          out_result_d = bus.core_return;
          out_err_d    = 1'b0;
        end else if (timer_q == TIMER_MAX) begin
          out_result_d = '0;
          out_err_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        out_valid_d = !out_fire;
        if (out_fire) begin
          job_cnt_d = job_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.core_a      = core_a_q;
  assign bus.core_b      = core_b_q;
  assign bus.core_start  = (state_q == S_RUN);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_err     = out_err_q;
  assign busy            = (state_q != S_IDLE) || !fifo_empty;
  assign job_cnt         = job_cnt_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb/tb_gcd_dispatch.sv - directed bench for gcd_dispatch with a behavioural gcd core
module tb_gcd_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] job_cnt;
  logic        spur_done = 1'b0;
  logic        model_done = 1'b0;
  logic [31:0] model_ret = '0;
  int          core_mode = 0;
  int          core_lat = 5;
  int          hi_cnt = 0;
  int          last_hi = 0;
  int          start_cycles = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  gcd_dispatch_if #(.DATA_W(32)) bus ();

  gcd_dispatch #(
    .DATA_W(32),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus),
    .busy    (busy),
    .job_cnt (job_cnt)
  );

  always #5 clk = ~clk;

  assign bus.core_done   = model_done | spur_done;
  assign bus.core_return = model_ret;

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a;
    logic [31:0] y = b;
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: mode 0 answers on its core_lat-th high cycle, mode 1 never answers.
  always @(negedge clk) begin
    if (bus.core_start) begin
      hi_cnt = hi_cnt + 1;
      start_cycles = start_cycles + 1;
      if (core_mode == 0 && hi_cnt == core_lat) begin
        model_done = 1'b1;
        model_ret  = gcd_ref(bus.core_a, bus.core_b);
      end else begin
        model_done = 1'b0;
      end
    end else begin
      if (hi_cnt != 0) last_hi = hi_cnt;
      hi_cnt = 0;
      model_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_result(input string tag, input logic [31:0] exp_res, input logic exp_err);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, bus.out_result, exp_res);
    chk({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s0;
    int stable;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(bus.core_start), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs", 32'(job_cnt), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_core_a", bus.core_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single job through the core
    core_mode = 0;
    core_lat = 5;
    push(32'd48, 32'd18);
    chk("t1_start_lat", 32'(bus.core_start), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_start", 32'(bus.core_start), 32'd1);
    chk("t1_core_a", bus.core_a, 32'd48);
    chk("t1_core_b", bus.core_b, 32'd18);
    pop_result("t1", 32'd6, 1'b0);
    wait_idle("t1_idle");
    chk("t1_start_len", 32'(last_hi), 32'd5);
    chk("t1_jobs", 32'(job_cnt), 32'd1);

    // Zero operands bypass the core
    s0 = start_cycles;
    push(32'd0, 32'd35);
    @(negedge clk);
    chk("t3_valid_n1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t3_valid_n2", 32'(bus.out_valid), 32'd1);
    pop_result("t3a", 32'd35, 1'b0);
    push(32'd21, 32'd0);
    pop_result("t3b", 32'd21, 1'b0);
    push(32'd0, 32'd0);
    pop_result("t3c", 32'd0, 1'b0);
    wait_idle("t3_idle");
    chk("t3_no_start", 32'(start_cycles - s0), 32'd0);
    chk("t3_jobs", 32'(job_cnt), 32'd4);

    // Backpressure: one job parked in RESP, four queued, then full
    core_lat = 2;
    push(32'd12, 32'd8);
    push(32'd9, 32'd6);
    push(32'd35, 32'd14);
    push(32'd100, 32'd75);
    push(32'd17, 32'd5);
    repeat (3) @(negedge clk);
    chk("t2_full", 32'(bus.in_ready), 32'd0);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_result == 32'd4 && !bus.out_err) stable++;
    end
    chk("t5_stable", 32'(stable), 32'd10);
    fork
      push(32'd27, 32'd18);
    join_none
    pop_result("t2_j1", 32'd4, 1'b0);
    pop_result("t2_j2", 32'd3, 1'b0);
    pop_result("t2_j3", 32'd7, 1'b0);
    pop_result("t2_j4", 32'd25, 1'b0);
    pop_result("t2_j5", 32'd1, 1'b0);
    pop_result("t5_held", 32'd9, 1'b0);
    wait_idle("t2_idle");
    chk("t2_jobs", 32'(job_cnt), 32'd10);

    // Hung core: timeout, then a late done is ignored
    core_mode = 1;
    push(32'd30, 32'd12);
    begin
      int n = 0;
      while (!bus.out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk);
    chk("t4_late_res", bus.out_result, 32'd0);
    chk("t4_late_err", 32'(bus.out_err), 32'd1);
    pop_result("t4", 32'd0, 1'b1);
    wait_idle("t4_idle");
    chk("t4_start_len", 32'(last_hi), 32'd16);
    chk("t4_jobs", 32'(job_cnt), 32'd11);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_spur_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_spur_busy", 32'(busy), 32'd0);
    chk("t4_spur_jobs", 32'(job_cnt), 32'd11);

    // Reset during RUN with jobs queued
    push(32'd10, 32'd4);
    push(32'd6, 32'd9);
    push(32'd8, 32'd12);
    repeat (2) @(negedge clk);
    chk("t6_running", 32'(bus.core_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_start_drop", 32'(bus.core_start), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_jobs", 32'(job_cnt), 32'd0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    core_mode = 0;
    core_lat = 3;
    repeat (3) @(negedge clk);
    chk("t6_flushed", 32'(busy), 32'd0);
    chk("t6_no_partial", 32'(bus.out_valid), 32'd0);
    push(32'd7, 32'd21);
    pop_result("t6", 32'd7, 1'b0);
    wait_idle("t6_idle");
    chk("t6_jobs_after", 32'(job_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
